// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_arb_pkg
//  Purpose  : Shared types and defaults for the SPI transaction arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package spi_arb_pkg;

    // Default SPI word width of the shared master
    localparam int DW_DEFAULT = 12;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin selector. Finds the first set request
//             scanning upward from ptr, wrapping modulo NREQ.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   idx,
    output logic            found
);

    // Scan from the lowest priority offset down so the offset closest to ptr wins
    always_comb begin
        int            j;
        logic [PW-1:0] jj;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = PW'(j);
            if (req[jj]) begin
                idx   = jj;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_txn_arbiter
//  Purpose  : Shares one SPI master (newd/din/dout/done) between NREQ
//             requesters with round-robin arbitration, a start-strobe
//             handshake against the master's sync clock, and a watchdog that
//             aborts transfers whose done edge never arrives.
//  Revision : 1.0  initial release
// ============================================================================
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = DW_DEFAULT,
    parameter int TMO_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,        // asynchronous, active low
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic               rsp_err,
    output logic [DW-1:0]      rsp_data,
    output logic               spi_newd,
    output logic [DW-1:0]      spi_din,
    input  logic               spi_sclk,
    input  logic [DW-1:0]      spi_dout,
    input  logic               spi_done,
    output logic               busy
);

    localparam int            PW       = $clog2(NREQ);
    localparam int            TW       = $clog2(TMO_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] pick_idx;
    logic          pick_found;
    logic          sclk_q;
    logic          done_q;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          sclk_rise;
    logic          done_rise;
    logic          timer_exp;

    assign sclk_rise  = spi_sclk & ~sclk_q;
    assign done_rise  = spi_done & ~done_q;
    assign timer_exp  = (timer == TMO_LAST);
    assign timer_next = (timer == '1) ? timer : timer + TW'(1);
    assign busy       = (state != IDLE);

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Edge-detect history for the master's sync clock and completion flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sclk_q <= spi_sclk;
            done_q <= spi_done;
        end
    end

    // Transaction sequencer: arbitration, launch handshake, completion and watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            timer     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            spi_newd  <= 1'b0;
            spi_din   <= '0;
        end else begin
            // Grant and response strobes last exactly one cycle
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (pick_found) begin
                        gnt      <= NREQ'(1) << pick_idx;
                        spi_din  <= req_data[int'(pick_idx)*DW +: DW];
                        owner    <= pick_idx;
                        ptr      <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
                        timer    <= '0;
                        spi_newd <= 1'b1;
                        state    <= LAUNCH;
                    end else begin
                        // Request withdrawn before it could be served
                        state <= IDLE;
                    end
                end
                LAUNCH: begin
                    timer <= timer_next;
                    if (timer_exp) begin
                        spi_newd  <= 1'b0;
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else if (sclk_rise) begin
                        // Master has sampled newd on this sync-clock edge
                        spi_newd <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer_next;
                    // A done edge on the expiry cycle still counts as success
                    if (done_rise) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_data  <= spi_dout;
                        state     <= RESP;
                    end else if (timer_exp) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
